pc_word_parser: RTL and testbench
=================================

# pc_word_parser

Front end of the PC configuration path. It accepts a stream of downstream words from the host-side input channel and decodes each word's code field. It then either overwrites one of `Nreg` configuration registers or pushes the payload onto one of `Nchan` configuration channels. Its register array and channel array feed the mapping stage that distributes configuration to SpikeFilter, SpikeGenerator, TimeMgr, TagSplit and BDIO. That stage also supplies the reset values for the registers.

## Interface
Parameters:
- `Nconf`, 16: payload width. This is the width of each config register and each channel word.
- `Nreg`, 64: number of configuration registers.
- `Nchan`, 1: number of configuration channels.
- `Ncode`, 8: code field width. Must satisfy `Nreg + Nchan <= 2**Ncode`.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-low; 0 = reset.
- `pc_in`, Channel, `Ncode+Nconf`: input words with `d = {code, payload}`; `v`/`a` handshake.
- `conf_reg_reset_vals`, in, `Nreg*Nconf`: value each register loads during reset.
- `conf_reg_out`, out, `Nreg*Nconf`: current register contents.
- `conf_reg_wr`, out, `Nreg`: one-hot, one-cycle pulse marking the register written this cycle.
- `conf_channel_out`, ChannelArray, `Nchan × Nconf`: configuration channels.
- `err_count`, out, 16: count of unmapped codes (see Configuration).

## Operation
- Channel transfer: a transfer occurs on a rising edge where `v && a` are both 1. Producers hold `d` stable while `v` is high and `a` is low.
- Hold stage: a single word register `held` with valid bit `held_v`.
- FSM with states EMPTY and HELD:
  - EMPTY → HELD on `pc_in` transfer.
  - HELD → EMPTY on commit with no new transfer.
  - HELD → HELD on commit together with a transfer, or on stall.
- `pc_in.a = reset && (!held_v || commit)`.
- Decoding of the held `code`:
  - `code < Nreg`: register write. Commit is unconditional. `conf_reg_out[code] <= payload` and `conf_reg_wr[code]` pulses.
  - `Nreg <= code < Nreg+Nchan`: channel push to slot `k = code-Nreg`. Commit happens only if the slot is free or draining (`!slot_v[k] || conf_channel_out[k].a`); `slot_d[k] <= payload` and `slot_v[k] <= 1`.
  - Any other code: unmapped. Commit is unconditional. The word is discarded and `err_count` increments.
- Channel slot `k`:
  - `conf_channel_out[k].v = slot_v[k]` and `.d = slot_d[k]`.
  - On the out transfer, `slot_v` clears unless it is reloaded in the same cycle.
- Reset values of outputs:
  - `conf_reg_out` equals `conf_reg_reset_vals`, sampled every reset cycle.
  - `conf_reg_wr` = 0.
  - All `slot_v` = 0 and `held_v` = 0.
  - `pc_in.a` = 0.
  - `err_count` = 0.
- Reset mid-operation: the held word and undelivered slot contents are discarded, not replayed.
- Register writes: back-to-back writes to the same register apply in order; the last one wins. A register write never stalls the input.
- Slot back-pressure: a stalled channel push blocks all later words, including register writes, so ordering is strictly preserved.

## Timing
- `pc_in` accepted at edge N:
  - Commit at edge N+1 at the earliest.
  - `conf_reg_out` and `conf_reg_wr` are visible after edge N+1.
  - Channel `v` rises after edge N+1.
- Throughput is one word per cycle while no slot stalls.
- There is no combinational path from `pc_in.v` to any output. `pc_in.a` depends combinationally on `conf_channel_out[*].a` through `commit`.

## Configuration
- `PC_PARSER_ERR_COUNT_EN` defined:
  - `err_count` is a 16-bit counter that saturates at 0xFFFF and increments once per unmapped word at its commit edge.
  - Reset clears it.
- `PC_PARSER_ERR_COUNT_EN` undefined:
  - `err_count` is tied to 0 and no counter logic is built.
  - Unmapped words are still discarded silently in one cycle.

## Structure
- Package `pc_parser_pkg`:
  - `Ncode` default.
  - Packed struct `pc_word_t {logic [Ncode-1:0] code; logic [Nconf-1:0] payload;}`.
  - Enum `parse_state_t {EMPTY, HELD}`.
  - Helper function `code_kind(code)` returning REG, CHAN or BAD.
- Sub-module `pc_chan_slot`: a one-entry output buffer with load/valid/ack, instantiated `Nchan` times in a generate loop.

## Test plan
- Reset with `conf_reg_reset_vals[22]=1000`, `[31]=3` and the rest 0, then release:
  - `conf_reg_out[22]=1000` and `[31]=3`.
  - `pc_in.a` is 0 during reset and 1 on the first cycle after it.
- Words `{5,0x1234}` then `{5,0xBEEF}` on consecutive cycles:
  - `conf_reg_wr[5]` pulses on two consecutive cycles.
  - Final `conf_reg_out[5]=0xBEEF`.
  - `pc_in.a` never drops.
- `{64,0xAAAA}` with `conf_channel_out[0].a=0` for 5 cycles, then `{3,0x0007}`:
  - Channel holds `v=1`, `d=0xAAAA`.
  - `pc_in.a=0` until the channel ack.
  - Register 3 writes exactly one cycle after the ack edge.
- Channel `a` tied to 1 with three pushes `{64,1}`, `{64,2}`, `{64,3}` back-to-back:
  - Three consecutive out transfers with `d` = 1, 2, 3.
  - No bubbles.
- `{200,0x1111}` with the macro defined: no register or channel effect, and `err_count` reads 1. Repeating it 70000 times saturates `err_count` at 0xFFFF.
- Reset asserted while the slot holds an undelivered word and `held_v=1`:
  - After release, channel `v=0` and no register changes.
  - The next word processes normally.

Source files
------------

// File: rtl/pc_parser_pkg.sv
// Shared types and decode helper for the PC configuration word parser.
package pc_parser_pkg;

   localparam int PC_NCODE = 8;
   localparam int PC_NCONF = 16;

   // One downstream word as it appears on the host channel.
   typedef struct packed {
      logic [PC_NCODE-1:0] code;
      logic [PC_NCONF-1:0] payload;
   } pc_word_t;

   // Hold-stage occupancy.
   typedef enum logic {
      EMPTY = 1'b0,
      HELD  = 1'b1
   } parse_state_t;

   // What a code field addresses.
   typedef enum logic [1:0] {
      REG  = 2'd0,
      CHAN = 2'd1,
      BAD  = 2'd2
   } code_kind_t;

   // Registers occupy codes [0, nreg), channels follow, everything above is unmapped.
   function automatic code_kind_t code_kind(input int code, input int nreg, input int nchan);
      if (code < nreg)
         return REG;
      else if (code < nreg + nchan)
         return CHAN;
      else
         return BAD;
   endfunction

endpackage

// File: rtl/pc_chan_slot.sv
// One-entry output buffer for a configuration channel: load fills it,
// ack drains it, and a load in the same cycle as the drain keeps it full.
module pc_chan_slot #(
   parameter int Nconf = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [Nconf-1:0] i_data,
   input  logic             i_ack,
   output logic             o_v,
   output logic [Nconf-1:0] o_d
);

   logic             r_v;
   logic [Nconf-1:0] r_d;

   // Valid flag: reload wins over the drain of the previous word.
   always_ff @(posedge clk) begin
      if (!reset)
         r_v <= 1'b0;
      else if (i_load)
         r_v <= 1'b1;
      else if (i_ack)
         r_v <= 1'b0;
   end

   // Payload capture; contents are meaningless while r_v is low.
   always_ff @(posedge clk) begin
      if (i_load)
         r_d <= i_data;
   end

   assign o_v = r_v;
   assign o_d = r_d;

endmodule

// File: rtl/pc_word_parser.sv
// PC configuration word parser: holds one input word, decodes its code field
// and either writes a configuration register, pushes into a channel slot, or
// discards it as unmapped.
// Optional feature macro: PC_PARSER_ERR_COUNT_EN (saturating unmapped-code counter).
module pc_word_parser
   import pc_parser_pkg::*;
#(
   parameter int Nconf = 16,
   parameter int Nreg  = 64,
   parameter int Nchan = 1,
   parameter int Ncode = PC_NCODE
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [Ncode+Nconf-1:0] pc_in_d,
   input  logic                   pc_in_v,
   output logic                   pc_in_a,
   input  logic [Nreg*Nconf-1:0]  conf_reg_reset_vals,
   output logic [Nreg*Nconf-1:0]  conf_reg_out,
   output logic [Nreg-1:0]        conf_reg_wr,
   output logic [Nchan*Nconf-1:0] conf_channel_out_d,
   output logic [Nchan-1:0]       conf_channel_out_v,
   input  logic [Nchan-1:0]       conf_channel_out_a,
   output logic [15:0]            err_count
);

   parse_state_t           r_state;
   parse_state_t           w_state_nxt;
   logic [Ncode+Nconf-1:0] r_held;
   logic [Ncode-1:0]       w_code;
   logic [Nconf-1:0]       w_payload;
   code_kind_t             w_kind;
   logic                   w_commit;
   logic                   w_xfer;
   logic [Nchan-1:0]       w_slot_sel;
   logic [Nchan-1:0]       w_slot_load;
   logic                   w_slot_ready;
   logic [Nreg-1:0]        w_reg_wr;

   assign w_code    = r_held[Ncode+Nconf-1:Nconf];
   assign w_payload = r_held[Nconf-1:0];
   assign w_kind    = code_kind(int'(w_code), Nreg, Nchan);

   // Pick the addressed channel slot and whether it can take a word this cycle.
   always_comb begin
      w_slot_sel   = '0;
      w_slot_ready = 1'b1;
      for (int k = 0; k < Nchan; k++) begin
         if (int'(w_code) == Nreg + k) begin
            w_slot_sel[k] = 1'b1;
            w_slot_ready  = !conf_channel_out_v[k] || conf_channel_out_a[k];
         end
      end
   end

   // Hold-stage control: commit, input ready and next occupancy.
   always_comb begin
      w_commit    = 1'b0;
      w_xfer      = 1'b0;
      w_state_nxt = r_state;
      if (r_state == HELD)
         w_commit = (w_kind != CHAN) || w_slot_ready;
      pc_in_a = reset && ((r_state == EMPTY) || w_commit);
      w_xfer  = pc_in_v && pc_in_a;
      if (w_xfer)
         w_state_nxt = HELD;
      else if (w_commit)
         w_state_nxt = EMPTY;
   end

   // Hold-stage occupancy register; reset drops any held word.
   always_ff @(posedge clk) begin
      if (!reset)
         r_state <= EMPTY;
      else
         r_state <= w_state_nxt;
   end

   // Capture the accepted word.
   always_ff @(posedge clk) begin
      if (w_xfer)
         r_held <= pc_in_d;
   end

   // One-hot register write strobe for a committing register word.
   always_comb begin
      w_reg_wr = '0;
      if (w_commit && (w_kind == REG)) begin
         for (int i = 0; i < Nreg; i++) begin
            if (int'(w_code) == i)
               w_reg_wr[i] = 1'b1;
         end
      end
   end

   // Register array: reloads from the mapping stage during reset, else takes writes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         conf_reg_out <= conf_reg_reset_vals;
      end else begin
         for (int i = 0; i < Nreg; i++) begin
            if (w_reg_wr[i])
               conf_reg_out[i*Nconf +: Nconf] <= w_payload;
         end
      end
   end

   // Write pulse is registered so it lines up with the new register value.
   always_ff @(posedge clk) begin
      if (!reset)
         conf_reg_wr <= '0;
      else
         conf_reg_wr <= w_reg_wr;
   end

   assign w_slot_load = w_slot_sel & {Nchan{w_commit && (w_kind == CHAN)}};

   for (genvar k = 0; k < Nchan; k++) begin : g_slot
      pc_chan_slot #(
         .Nconf (Nconf)
      ) u_slot (
         .clk    (clk),
         .reset  (reset),
         .i_load (w_slot_load[k]),
         .i_data (w_payload),
         .i_ack  (conf_channel_out_a[k]),
         .o_v    (conf_channel_out_v[k]),
         .o_d    (conf_channel_out_d[k*Nconf +: Nconf])
      );
   end

`ifdef PC_PARSER_ERR_COUNT_EN
   logic [15:0] r_err_count;

   // Saturating count of unmapped words, bumped on their commit edge.
   always_ff @(posedge clk) begin
      if (!reset)
         r_err_count <= 16'd0;
      else if (w_commit && (w_kind == BAD) && (r_err_count != 16'hFFFF))
         r_err_count <= r_err_count + 16'd1;
   end

   assign err_count = r_err_count;
`else
   assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_pc_word_parser.sv
// Self-checking bench for pc_word_parser (default parameters).
module tb_pc_word_parser;

   localparam int NCONF = 16;
   localparam int NREG  = 64;
   localparam int NCHAN = 1;
   localparam int NCODE = 8;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NCODE+NCONF-1:0] pc_in_d;
   logic                   pc_in_v;
   logic                   pc_in_a;
   logic [NREG*NCONF-1:0]  conf_reg_reset_vals;
   logic [NREG*NCONF-1:0]  conf_reg_out;
   logic [NREG-1:0]        conf_reg_wr;
   logic [NCHAN*NCONF-1:0] conf_channel_out_d;
   logic [NCHAN-1:0]       conf_channel_out_v;
   logic [NCHAN-1:0]       conf_channel_out_a;
   logic [15:0]            err_count;

   int checks   = 0;
   int failures = 0;

   logic [15:0] rst_vals [NREG];
   logic [15:0] exp_reg  [NREG];

   logic [23:0] acc_q    [$];
   logic [15:0] chan_obs [$];
   int          wr_pulses = 0;

   always #5 clk = ~clk;

   pc_word_parser #(
      .Nconf (NCONF),
      .Nreg  (NREG),
      .Nchan (NCHAN),
      .Ncode (NCODE)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .pc_in_d             (pc_in_d),
      .pc_in_v             (pc_in_v),
      .pc_in_a             (pc_in_a),
      .conf_reg_reset_vals (conf_reg_reset_vals),
      .conf_reg_out        (conf_reg_out),
      .conf_reg_wr         (conf_reg_wr),
      .conf_channel_out_d  (conf_channel_out_d),
      .conf_channel_out_v  (conf_channel_out_v),
      .conf_channel_out_a  (conf_channel_out_a),
      .err_count           (err_count)
   );

   // Record every input transfer, channel transfer and register write pulse.
   always @(posedge clk) begin
      if (pc_in_v && pc_in_a)
         acc_q.push_back(pc_in_d);
      if (conf_channel_out_v[0] && conf_channel_out_a[0])
         chan_obs.push_back(conf_channel_out_d);
      wr_pulses <= wr_pulses + $countones(conf_reg_wr);
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] regv(input int i);
      return conf_reg_out[i*NCONF +: NCONF];
   endfunction

   task automatic load_reset_vals();
      for (int i = 0; i < NREG; i++)
         conf_reg_reset_vals[i*NCONF +: NCONF] = rst_vals[i];
   endtask

   task automatic test_reset();
      for (int i = 0; i < NREG; i++) rst_vals[i] = 16'd0;
      rst_vals[22] = 16'd1000;
      rst_vals[31] = 16'd3;
      load_reset_vals();
      reset = 1'b0; pc_in_v = 1'b0; pc_in_d = '0; conf_channel_out_a = 1'b0;
      @(negedge clk);
      repeat (2) @(negedge clk);
      #1;
      checks++; if (pc_in_a !== 1'b0) begin failures++; $display("FAIL reset_a_low got=%b exp=0", pc_in_a); end
      checks++; if (regv(22) !== 16'd1000) begin failures++; $display("FAIL reset_reg22 got=%0d exp=1000", regv(22)); end
      checks++; if (regv(31) !== 16'd3) begin failures++; $display("FAIL reset_reg31 got=%0d exp=3", regv(31)); end
      checks++; if (conf_reg_wr !== 64'd0) begin failures++; $display("FAIL reset_wr got=%h exp=0", conf_reg_wr); end
      checks++; if (conf_channel_out_v !== 1'b0) begin failures++; $display("FAIL reset_chan_v got=%b exp=0", conf_channel_out_v); end
      checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err got=%h exp=0", err_count); end
      reset = 1'b1;
      #1;
      checks++; if (pc_in_a !== 1'b1) begin failures++; $display("FAIL release_a_high got=%b exp=1", pc_in_a); end
      @(negedge clk); #1;
      checks++; if (regv(22) !== 16'd1000) begin failures++; $display("FAIL release_reg22 got=%0d exp=1000", regv(22)); end
      checks++; if (regv(5) !== 16'd0) begin failures++; $display("FAIL release_reg5 got=%0d exp=0", regv(5)); end
      for (int i = 0; i < NREG; i++) exp_reg[i] = rst_vals[i];
   endtask

   task automatic test_reg_back_to_back();
      @(negedge clk);
      pc_in_d = {8'd5, 16'h1234}; pc_in_v = 1'b1; #1;
      checks++; if (pc_in_a !== 1'b1) begin failures++; $display("FAIL b2b_a0 got=%b exp=1", pc_in_a); end
      @(negedge clk);
      pc_in_d = {8'd5, 16'hBEEF}; #1;
      checks++; if (pc_in_a !== 1'b1) begin failures++; $display("FAIL b2b_a1 got=%b exp=1", pc_in_a); end
      checks++; if (conf_reg_wr !== 64'd0) begin failures++; $display("FAIL b2b_wr_early got=%h exp=0", conf_reg_wr); end
      @(negedge clk);
      pc_in_v = 1'b0; #1;
      checks++; if (pc_in_a !== 1'b1) begin failures++; $display("FAIL b2b_a2 got=%b exp=1", pc_in_a); end
      checks++; if (conf_reg_wr !== (64'd1 << 5)) begin failures++; $display("FAIL b2b_wr_first got=%h exp=%h", conf_reg_wr, 64'd1 << 5); end
      checks++; if (regv(5) !== 16'h1234) begin failures++; $display("FAIL b2b_reg_first got=%h exp=1234", regv(5)); end
      @(negedge clk); #1;
      checks++; if (conf_reg_wr !== (64'd1 << 5)) begin failures++; $display("FAIL b2b_wr_second got=%h exp=%h", conf_reg_wr, 64'd1 << 5); end
      checks++; if (regv(5) !== 16'hBEEF) begin failures++; $display("FAIL b2b_reg_final got=%h exp=beef", regv(5)); end
      @(negedge clk); #1;
      checks++; if (conf_reg_wr !== 64'd0) begin failures++; $display("FAIL b2b_wr_end got=%h exp=0", conf_reg_wr); end
      exp_reg[5] = 16'hBEEF;
   endtask

   task automatic test_chan_stall();
      conf_channel_out_a = 1'b0;
      @(negedge clk);
      pc_in_d = {8'd64, 16'hAAAA}; pc_in_v = 1'b1;
      @(negedge clk);
      pc_in_d = {8'd64, 16'h5555}; #1;
      checks++; if (pc_in_a !== 1'b1) begin failures++; $display("FAIL stall_a_free got=%b exp=1", pc_in_a); end
      @(negedge clk);
      pc_in_d = {8'd3, 16'h0007}; #1;
      for (int c = 0; c < 5; c++) begin
         checks++; if (pc_in_a !== 1'b0) begin failures++; $display("FAIL stall_a_low c=%0d got=%b exp=0", c, pc_in_a); end
         checks++; if (conf_channel_out_v !== 1'b1 || conf_channel_out_d !== 16'hAAAA) begin failures++; $display("FAIL stall_chan c=%0d got v=%b d=%h exp v=1 d=aaaa", c, conf_channel_out_v, conf_channel_out_d); end
         checks++; if (conf_reg_wr !== 64'd0) begin failures++; $display("FAIL stall_wr c=%0d got=%h exp=0", c, conf_reg_wr); end
         @(negedge clk); #1;
      end
      conf_channel_out_a = 1'b1; #1;
      checks++; if (pc_in_a !== 1'b1) begin failures++; $display("FAIL stall_a_on_ack got=%b exp=1", pc_in_a); end
      @(negedge clk);
      pc_in_v = 1'b0; conf_channel_out_a = 1'b0; #1;
      checks++; if (conf_reg_wr !== 64'd0) begin failures++; $display("FAIL stall_wr_ackedge got=%h exp=0", conf_reg_wr); end
      checks++; if (conf_channel_out_v !== 1'b1 || conf_channel_out_d !== 16'h5555) begin failures++; $display("FAIL stall_reload got v=%b d=%h exp v=1 d=5555", conf_channel_out_v, conf_channel_out_d); end
      @(negedge clk); #1;
      checks++; if (conf_reg_wr !== (64'd1 << 3)) begin failures++; $display("FAIL stall_wr3 got=%h exp=%h", conf_reg_wr, 64'd1 << 3); end
      checks++; if (regv(3) !== 16'h0007) begin failures++; $display("FAIL stall_reg3 got=%h exp=0007", regv(3)); end
      exp_reg[3] = 16'h0007;
      conf_channel_out_a = 1'b1;
      @(negedge clk); #1;
      checks++; if (conf_channel_out_v !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", conf_channel_out_v); end
      conf_channel_out_a = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_d;
      conf_channel_out_a = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c < 3) begin
            pc_in_d = {8'd64, 16'(c + 1)}; pc_in_v = 1'b1;
         end else begin
            pc_in_v = 1'b0;
         end
         #1;
         if (c < 3) begin
            checks++; if (pc_in_a !== 1'b1) begin failures++; $display("FAIL btb_a c=%0d got=%b exp=1", c, pc_in_a); end
         end
         if (c >= 2 && c <= 4) begin
            exp_d = 16'(c - 1);
            checks++; if (conf_channel_out_v !== 1'b1 || conf_channel_out_d !== exp_d) begin failures++; $display("FAIL btb_out c=%0d got v=%b d=%h exp v=1 d=%h", c, conf_channel_out_v, conf_channel_out_d, exp_d); end
         end else begin
            checks++; if (conf_channel_out_v !== 1'b0) begin failures++; $display("FAIL btb_idle c=%0d got v=%b exp 0", c, conf_channel_out_v); end
         end
      end
      conf_channel_out_a = 1'b0;
   endtask

   task automatic test_unmapped();
      logic [15:0] exp_err;
      int          bad_regs;
      int          reps;
`ifdef PC_PARSER_ERR_COUNT_EN
      exp_err = 16'd1;
      reps    = 69999;
`else
      exp_err = 16'd0;
      reps    = 20;
`endif
      @(negedge clk);
      pc_in_d = {8'd200, 16'h1111}; pc_in_v = 1'b1;
      @(negedge clk);
      pc_in_v = 1'b0; #1;
      checks++; if (pc_in_a !== 1'b1) begin failures++; $display("FAIL bad_a got=%b exp=1", pc_in_a); end
      @(negedge clk); #1;
      checks++; if (conf_reg_wr !== 64'd0) begin failures++; $display("FAIL bad_wr got=%h exp=0", conf_reg_wr); end
      checks++; if (conf_channel_out_v !== 1'b0) begin failures++; $display("FAIL bad_chan got=%b exp=0", conf_channel_out_v); end
      checks++; if (err_count !== exp_err) begin failures++; $display("FAIL bad_err1 got=%h exp=%h", err_count, exp_err); end
      bad_regs = 0;
      for (int i = 0; i < NREG; i++) if (regv(i) !== exp_reg[i]) bad_regs++;
      checks++; if (bad_regs != 0) begin failures++; $display("FAIL bad_regs_changed got=%0d exp=0", bad_regs); end
      @(negedge clk);
      pc_in_d = {8'd200, 16'h1111}; pc_in_v = 1'b1;
      repeat (reps) @(negedge clk);
      pc_in_v = 1'b0;
      repeat (3) @(negedge clk);
      #1;
`ifdef PC_PARSER_ERR_COUNT_EN
      exp_err = 16'hFFFF;
`endif
      checks++; if (err_count !== exp_err) begin failures++; $display("FAIL bad_err_sat got=%h exp=%h", err_count, exp_err); end
      checks++; if (conf_channel_out_v !== 1'b0) begin failures++; $display("FAIL bad_chan_end got=%b exp=0", conf_channel_out_v); end
   endtask

   task automatic test_reset_mid();
      conf_channel_out_a = 1'b0;
      @(negedge clk);
      pc_in_d = {8'd64, 16'hCCCC}; pc_in_v = 1'b1;
      @(negedge clk);
      pc_in_d = {8'd64, 16'hDDDD};
      @(negedge clk);
      pc_in_v = 1'b0; #1;
      checks++; if (conf_channel_out_v !== 1'b1 || pc_in_a !== 1'b0) begin failures++; $display("FAIL mid_setup got v=%b a=%b exp v=1 a=0", conf_channel_out_v, pc_in_a); end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1; #1;
      checks++; if (conf_channel_out_v !== 1'b0) begin failures++; $display("FAIL mid_chan_v got=%b exp=0", conf_channel_out_v); end
      checks++; if (pc_in_a !== 1'b1) begin failures++; $display("FAIL mid_a got=%b exp=1", pc_in_a); end
      for (int i = 0; i < NREG; i++) exp_reg[i] = rst_vals[i];
      @(negedge clk); #1;
      checks++; if (conf_reg_wr !== 64'd0) begin failures++; $display("FAIL mid_wr got=%h exp=0", conf_reg_wr); end
      checks++; if (conf_channel_out_v !== 1'b0) begin failures++; $display("FAIL mid_no_replay got=%b exp=0", conf_channel_out_v); end
      for (int i = 0; i < NREG; i++) begin
         checks++; if (regv(i) !== exp_reg[i]) begin failures++; $display("FAIL mid_reg%0d got=%h exp=%h", i, regv(i), exp_reg[i]); end
      end
      pc_in_d = {8'd64, 16'h4242}; pc_in_v = 1'b1;
      @(negedge clk);
      pc_in_d = {8'd7, 16'h0077};
      @(negedge clk);
      pc_in_v = 1'b0; #1;
      checks++; if (conf_channel_out_v !== 1'b1 || conf_channel_out_d !== 16'h4242) begin failures++; $display("FAIL mid_next_chan got v=%b d=%h exp v=1 d=4242", conf_channel_out_v, conf_channel_out_d); end
      @(negedge clk); #1;
      checks++; if (regv(7) !== 16'h0077 || conf_reg_wr !== (64'd1 << 7)) begin failures++; $display("FAIL mid_next_reg got=%h wr=%h exp=0077 wr=%h", regv(7), conf_reg_wr, 64'd1 << 7); end
      exp_reg[7] = 16'h0077;
      conf_channel_out_a = 1'b1;
      @(negedge clk); #1;
      checks++; if (conf_channel_out_v !== 1'b0) begin failures++; $display("FAIL mid_drain got=%b exp=0", conf_channel_out_v); end
      conf_channel_out_a = 1'b0;
   endtask

   task automatic test_random();
      int          acc_start, chan_start, wr_start, seen, nreg, nbad, r;
      logic [7:0]  code;
      logic [15:0] exp_chan [$];
      logic [15:0] exp_err;
      @(negedge clk);
      reset = 1'b0; pc_in_v = 1'b0; conf_channel_out_a = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < NREG; i++) exp_reg[i] = rst_vals[i];
      @(negedge clk);
      acc_start  = acc_q.size();
      chan_start = chan_obs.size();
      wr_start   = wr_pulses;
      seen       = acc_q.size();
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (!pc_in_v || acc_q.size() != seen) begin
            seen = acc_q.size();
            if ($urandom_range(3) != 0) begin
               r = $urandom_range(9);
               if (r < 6)      code = 8'($urandom_range(63));
               else if (r < 9) code = 8'd64;
               else            code = 8'($urandom_range(255, 65));
               pc_in_d = {code, 16'($urandom)};
               pc_in_v = 1'b1;
            end else begin
               pc_in_v = 1'b0;
            end
         end
         conf_channel_out_a = 1'($urandom_range(1));
         @(negedge clk);
      end
      pc_in_v = 1'b0; conf_channel_out_a = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      nreg = 0; nbad = 0;
      for (int i = acc_start; i < acc_q.size(); i++) begin
         code = acc_q[i][23:16];
         if (code < 8'd64) begin
            exp_reg[code] = acc_q[i][15:0];
            nreg++;
         end else if (code == 8'd64) begin
            exp_chan.push_back(acc_q[i][15:0]);
         end else begin
            nbad++;
         end
      end
`ifdef PC_PARSER_ERR_COUNT_EN
      exp_err = 16'(nbad);
`else
      exp_err = 16'd0;
`endif
      checks++; if (acc_q.size() - acc_start < 100) begin failures++; $display("FAIL rnd_progress got=%0d exp>=100", acc_q.size() - acc_start); end
      for (int i = 0; i < NREG; i++) begin
         checks++; if (regv(i) !== exp_reg[i]) begin failures++; $display("FAIL rnd_reg%0d got=%h exp=%h", i, regv(i), exp_reg[i]); end
      end
      checks++; if (wr_pulses - wr_start != nreg) begin failures++; $display("FAIL rnd_wr_count got=%0d exp=%0d", wr_pulses - wr_start, nreg); end
      checks++; if (chan_obs.size() - chan_start != exp_chan.size()) begin failures++; $display("FAIL rnd_chan_count got=%0d exp=%0d", chan_obs.size() - chan_start, exp_chan.size()); end
      for (int i = 0; i < exp_chan.size() && chan_start + i < chan_obs.size(); i++) begin
         checks++; if (chan_obs[chan_start + i] !== exp_chan[i]) begin failures++; $display("FAIL rnd_chan%0d got=%h exp=%h", i, chan_obs[chan_start + i], exp_chan[i]); end
      end
      checks++; if (err_count !== exp_err) begin failures++; $display("FAIL rnd_err got=%h exp=%h", err_count, exp_err); end
      checks++; if (conf_channel_out_v !== 1'b0) begin failures++; $display("FAIL rnd_chan_idle got=%b exp=0", conf_channel_out_v); end
   endtask

   initial begin
      reset              = 1'b0;
      pc_in_v            = 1'b0;
      pc_in_d            = '0;
      conf_channel_out_a = 1'b0;
      conf_reg_reset_vals = '0;
      test_reset();
      test_reg_back_to_back();
      test_chan_stall();
      test_back_to_back();
      test_unmapped();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
